sd_dac_multi: RTL and testbench

Parametrised multi-channel 1-bit audio DAC. It is the successor to the two-channel fixed 16-bit PWM accumulator DAC. It adds a configurable channel count and sample width, a frame FIFO with a valid/ready handshake, run-time signed/unsigned input format, and underrun detection. It sits between the audio mixer and the FPGA audio pins, and each `dac_out` bit drives an external RC low-pass filter.

---
 rtl/sd_dac_multi.sv | 139 +++++++++++++
 tb/tb_sd_dac_multi.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dac_multi.sv
// sd_dac_multi: multi-channel 1-bit audio DAC with a frame FIFO, signed/offset-binary input and underrun detection.
// Define SD_DAC_ORDER2_EN to replace each first-order accumulator with a second-order sigma-delta modulator.
module sd_dac_multi #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [CHANNELS*WIDTH-1:0]     s_data,
  input  logic                          fmt_signed,
  input  logic                          next_sample,
  output logic [CHANNELS-1:0]           dac_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [7:0]                    underrun_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] LVL_FULL = PW'(FIFO_DEPTH);

  logic [CHANNELS*WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]             r_wptr;
  logic [PW-1:0]             r_rptr;
  logic [PW-1:0]             r_level;
  logic                      r_underrun;
  logic [7:0]                r_ucnt;

  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_tick_empty;
  logic [CHANNELS*WIDTH-1:0] w_head;

  assign s_ready      = (r_level != LVL_FULL);
  assign fifo_level   = r_level;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_ucnt;

  always_comb begin
    w_empty      = (r_wptr == r_rptr);
    w_push       = s_valid && s_ready;
    w_pop        = next_sample && !w_empty;
    w_tick_empty = next_sample && w_empty;
    w_head       = r_mem[r_rptr[AW-1:0]];
  end

  // Storage is not reset: resetting the pointers is enough to discard frames in flight.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + PW'(1);
        2'b01:   r_level <= r_level - PW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underrun <= 1'b0;
      r_ucnt     <= '0;
    end else begin
      r_underrun <= w_tick_empty;
      if (w_tick_empty && (r_ucnt != '1)) r_ucnt <= r_ucnt + 8'd1;
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [WIDTH-1:0] r_sample;
    logic             r_dac;
    logic [WIDTH-1:0] w_raw;

    assign w_raw      = w_head[n*WIDTH +: WIDTH];
    assign dac_out[n] = r_dac;

    // Two's complement becomes offset-binary by flipping the MSB; format is captured at pop time.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_sample <= '0;
      else if (w_pop) r_sample <= {w_raw[WIDTH-1] ^ fmt_signed, w_raw[WIDTH-2:0]};
    end

`ifdef SD_DAC_ORDER2_EN
    localparam int IW = WIDTH + 4;
    logic signed [IW-1:0] r_i1;
    logic signed [IW-1:0] r_i2;
    logic signed [IW-1:0] w_x;
    logic signed [IW-1:0] w_fb;
    logic signed [IW-1:0] w_i1_next;
    logic signed [IW-1:0] w_i2_next;

    always_comb begin
      w_x  = signed'(IW'(r_sample));
      w_fb = '0;
      if (r_dac) w_fb[WIDTH] = 1'b1;
      w_i1_next = r_i1 + w_x - w_fb;
      w_i2_next = r_i2 + r_i1 - w_fb;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_i1  <= '0;
        r_i2  <= '0;
        r_dac <= 1'b0;
      end else begin
        r_i1  <= w_i1_next;
        r_i2  <= w_i2_next;
        r_dac <= ~w_i2_next[IW-1];
      end
    end
`else
    logic [WIDTH:0] r_acc;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_acc <= '0;
        r_dac <= 1'b0;
      end else begin
        r_acc <= {1'b0, r_acc[WIDTH-1:0]} + {1'b0, r_sample};
        r_dac <= r_acc[WIDTH];
      end
    end
`endif
  end

endmodule

// File: tb/tb_sd_dac_multi.sv
// Self-checking bench for sd_dac_multi (default first-order build): a queue-and-arithmetic reference
// model predicts FIFO state, samples, underrun bookkeeping and every modulator output bit.
module tb_sd_dac_multi;
  localparam int     CH = 2;
  localparam int     W  = 16;
  localparam int     D  = 4;
  localparam longint M  = 65536;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s_valid = 1'b0;
  logic            fmt_signed = 1'b0;
  logic            next_sample = 1'b0;
  logic [CH*W-1:0] s_data = '0;
  logic            s_ready;
  logic            underrun;
  logic [CH-1:0]   dac_out;
  logic [2:0]      fifo_level;
  logic [7:0]      underrun_cnt;

  int passed = 0;
  int total  = 0;

  // Reference model: FIFO as a queue, modulator as a cumulative sum whose multiples of 2^W are the 1s.
  logic [CH*W-1:0] mq[$];
  longint          m_S [CH];
  logic [W-1:0]    m_sample [CH];
  logic [CH-1:0]   m_dac;
  logic [CH-1:0]   m_carry;
  logic            m_underrun;
  int              m_ucnt;

  sd_dac_multi #(.CHANNELS(CH), .WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fmt_signed(fmt_signed), .next_sample(next_sample), .dac_out(dac_out),
    .fifo_level(fifo_level), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] conv(input logic [W-1:0] s, input logic f);
    return f ? W'(int'(s) + 32768) : s;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_dac = '0;
    m_carry = '0;
    m_underrun = 1'b0;
    m_ucnt = 0;
    for (int n = 0; n < CH; n++) begin
      m_S[n] = 0;
      m_sample[n] = '0;
    end
  endtask

  task automatic model_step();
    logic [CH*W-1:0] fr;
    int sz;
    sz = mq.size();
    m_underrun = next_sample && (sz == 0);
    if (m_underrun && m_ucnt < 255) m_ucnt++;
    for (int n = 0; n < CH; n++) begin
      m_dac[n] = m_carry[n];
      m_carry[n] = ((m_S[n] + longint'(m_sample[n])) / M) != (m_S[n] / M);
      m_S[n] += longint'(m_sample[n]);
    end
    if (next_sample && sz > 0) begin
      fr = mq.pop_front();
      for (int n = 0; n < CH; n++) m_sample[n] = conv(fr[n*W +: W], fmt_signed);
    end
    if (s_valid && sz < D) mq.push_back(s_data);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) step();
    total++; if (s_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", s_ready); else passed++;
    total++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else passed++;
    total++; if (underrun_cnt !== 8'd0) $display("FAIL reset_ucnt: got %0d want 0", underrun_cnt); else passed++;
    total++; if (dut.g_ch[0].r_sample !== 16'h0 || dut.g_ch[1].r_sample !== 16'h0)
      $display("FAIL reset_sample: got %h/%h want 0/0", dut.g_ch[0].r_sample, dut.g_ch[1].r_sample); else passed++;
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      total++; if (dac_out !== 2'b00) $display("FAIL idle_dac: cycle %0d got %b want 00", i, dac_out); else passed++;
    end
  endtask

  task automatic test_duty(input logic [W-1:0] c0, input logic [W-1:0] c1, input logic f, input string nm);
    int ones [CH];
    longint diff;
    logic [W-1:0] e [CH];
    localparam int N = 4096;
    e[0] = conv(c0, f);
    e[1] = conv(c1, f);
    fmt_signed = f;
    s_data = {c1, c0};
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    next_sample = 1'b1;
    step();
    next_sample = 1'b0;
    total++; if (dut.g_ch[0].r_sample !== e[0] || dut.g_ch[1].r_sample !== e[1])
      $display("FAIL %s_sample: got %h/%h want %h/%h", nm, dut.g_ch[0].r_sample, dut.g_ch[1].r_sample, e[0], e[1]);
    else passed++;
    step();
    total++; if (dac_out !== m_dac) $display("FAIL %s_dac_pre: got %b want %b", nm, dac_out, m_dac); else passed++;
    ones[0] = 0;
    ones[1] = 0;
    for (int i = 0; i < N; i++) begin
      step();
      total++; if (dac_out !== m_dac) $display("FAIL %s_dac: cycle %0d got %b want %b", nm, i, dac_out, m_dac); else passed++;
      for (int n = 0; n < CH; n++) ones[n] += int'(dac_out[n]);
    end
    for (int n = 0; n < CH; n++) begin
      diff = longint'(ones[n]) * M - longint'(N) * longint'(e[n]);
      total++; if (diff <= -M || diff >= M)
        $display("FAIL %s_duty_ch%0d: got %0d ones in %0d want about %0d*%0d/65536", nm, n, ones[n], N, N, e[n]);
      else passed++;
    end
  endtask

  task automatic test_fifo_full();
    logic [CH*W-1:0] fr [D];
    fmt_signed = 1'b0;
    for (int k = 0; k < D; k++) begin
      fr[k] = $urandom;
      s_data = fr[k];
      s_valid = 1'b1;
      step();
      total++; if (fifo_level !== 3'(k + 1)) $display("FAIL fill_level: got %0d want %0d", fifo_level, k + 1); else passed++;
    end
    total++; if (s_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", s_ready); else passed++;
    s_data = ~fr[0];
    step();
    s_valid = 1'b0;
    total++; if (fifo_level !== 3'd4) $display("FAIL full_ignore: level got %0d want 4", fifo_level); else passed++;
    next_sample = 1'b1;
    step();
    next_sample = 1'b0;
    total++; if (s_ready !== 1'b1 || fifo_level !== 3'd3)
      $display("FAIL full_pop: ready/level got %b/%0d want 1/3", s_ready, fifo_level); else passed++;
    total++; if ({dut.g_ch[1].r_sample, dut.g_ch[0].r_sample} !== fr[0])
      $display("FAIL order0: got %h want %h", {dut.g_ch[1].r_sample, dut.g_ch[0].r_sample}, fr[0]); else passed++;
    for (int k = 1; k < D; k++) begin
      step();
      next_sample = 1'b1;
      step();
      next_sample = 1'b0;
      total++; if ({dut.g_ch[1].r_sample, dut.g_ch[0].r_sample} !== fr[k])
        $display("FAIL order%0d: got %h want %h", k, {dut.g_ch[1].r_sample, dut.g_ch[0].r_sample}, fr[k]); else passed++;
    end
    total++; if (fifo_level !== 3'd0) $display("FAIL drain_level: got %0d want 0", fifo_level); else passed++;
  endtask

  task automatic test_underrun();
    logic [W-1:0] h0, h1;
    h0 = m_sample[0];
    h1 = m_sample[1];
    for (int k = 0; k < 3; k++) begin
      next_sample = 1'b1;
      step();
      next_sample = 1'b0;
      total++; if (underrun !== 1'b1) $display("FAIL ur_pulse%0d: got %b want 1", k, underrun); else passed++;
      step();
      total++; if (underrun !== 1'b0) $display("FAIL ur_clear%0d: got %b want 0", k, underrun); else passed++;
    end
    total++; if (underrun_cnt !== 8'd3) $display("FAIL ur_cnt3: got %0d want 3", underrun_cnt); else passed++;
    total++; if (dut.g_ch[0].r_sample !== h0 || dut.g_ch[1].r_sample !== h1)
      $display("FAIL ur_hold: got %h/%h want %h/%h", dut.g_ch[0].r_sample, dut.g_ch[1].r_sample, h0, h1); else passed++;
    next_sample = 1'b1;
    for (int k = 0; k < 300; k++) begin
      step();
      total++; if (underrun !== 1'b1 || underrun_cnt !== 8'(m_ucnt))
        $display("FAIL ur_run%0d: got %b/%0d want 1/%0d", k, underrun, underrun_cnt, m_ucnt); else passed++;
    end
    next_sample = 1'b0;
    step();
    total++; if (underrun_cnt !== 8'd255) $display("FAIL ur_sat: got %0d want 255", underrun_cnt); else passed++;
  endtask

  task automatic test_push_tick();
    logic [CH*W-1:0] f, g;
    logic [W-1:0] h0;
    f = $urandom;
    g = $urandom;
    h0 = m_sample[0];
    fmt_signed = 1'b1;
    s_data = f;
    s_valid = 1'b1;
    next_sample = 1'b1;
    step();
    total++; if (underrun !== 1'b1 || fifo_level !== 3'd1)
      $display("FAIL pt_empty: underrun/level got %b/%0d want 1/1", underrun, fifo_level); else passed++;
    total++; if (dut.g_ch[0].r_sample !== h0) $display("FAIL pt_hold: got %h want %h", dut.g_ch[0].r_sample, h0); else passed++;
    s_data = g;
    step();
    s_valid = 1'b0;
    next_sample = 1'b0;
    total++; if (underrun !== 1'b0 || fifo_level !== 3'd1)
      $display("FAIL pt_both: underrun/level got %b/%0d want 0/1", underrun, fifo_level); else passed++;
    total++; if (dut.g_ch[0].r_sample !== conv(f[W-1:0], 1'b1) || dut.g_ch[1].r_sample !== conv(f[2*W-1:W], 1'b1))
      $display("FAIL pt_pop_f: got %h/%h", dut.g_ch[0].r_sample, dut.g_ch[1].r_sample); else passed++;
    fmt_signed = 1'b0;
    next_sample = 1'b1;
    step();
    next_sample = 1'b0;
    total++; if ({dut.g_ch[1].r_sample, dut.g_ch[0].r_sample} !== g || fifo_level !== 3'd0)
      $display("FAIL pt_pop_g: got %h level %0d want %h level 0", {dut.g_ch[1].r_sample, dut.g_ch[0].r_sample}, fifo_level, g);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      s_valid = ($urandom_range(0, 99) < ((i < 1000) ? 70 : 15));
      s_data = $urandom;
      fmt_signed = $urandom_range(0, 1);
      next_sample = ($urandom_range(0, 3) == 0);
      step();
      total++; if (dac_out !== m_dac) $display("FAIL rnd_dac: cycle %0d got %b want %b", i, dac_out, m_dac); else passed++;
      total++; if (fifo_level !== 3'(mq.size()) || s_ready !== (mq.size() != D))
        $display("FAIL rnd_fifo: cycle %0d level/ready got %0d/%b want %0d/%b", i, fifo_level, s_ready, mq.size(), mq.size() != D);
      else passed++;
      total++; if (underrun !== m_underrun || underrun_cnt !== 8'(m_ucnt))
        $display("FAIL rnd_ur: cycle %0d got %b/%0d want %b/%0d", i, underrun, underrun_cnt, m_underrun, m_ucnt); else passed++;
      total++; if (dut.g_ch[0].r_sample !== m_sample[0] || dut.g_ch[1].r_sample !== m_sample[1])
        $display("FAIL rnd_sample: cycle %0d got %h/%h want %h/%h", i, dut.g_ch[0].r_sample, dut.g_ch[1].r_sample,
                 m_sample[0], m_sample[1]);
      else passed++;
    end
    s_valid = 1'b0;
    next_sample = 1'b0;
  endtask

  task automatic test_reset_mid();
    s_valid = 1'b1;
    s_data = 32'hC000_4000;
    fmt_signed = 1'b0;
    repeat (2) step();
    s_valid = 1'b0;
    next_sample = 1'b1;
    step();
    next_sample = 1'b0;
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    total++; if (dac_out !== 2'b00 || fifo_level !== 3'd0 || s_ready !== 1'b1)
      $display("FAIL mid_rst_fifo: dac/level/ready got %b/%0d/%b want 00/0/1", dac_out, fifo_level, s_ready); else passed++;
    total++; if (underrun !== 1'b0 || underrun_cnt !== 8'd0)
      $display("FAIL mid_rst_ur: got %b/%0d want 0/0", underrun, underrun_cnt); else passed++;
    total++; if (dut.g_ch[0].r_sample !== 16'h0 || dut.g_ch[1].r_sample !== 16'h0)
      $display("FAIL mid_rst_sample: got %h/%h want 0/0", dut.g_ch[0].r_sample, dut.g_ch[1].r_sample); else passed++;
    model_reset();
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (dac_out !== m_dac || fifo_level !== 3'(mq.size()))
        $display("FAIL post_rst: cycle %0d dac/level got %b/%0d want %b/%0d", i, dac_out, fifo_level, m_dac, mq.size());
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_duty(16'h8000, 16'h0000, 1'b0, "half");
    test_duty(16'hFFFF, 16'h0001, 1'b0, "edge");
    test_duty(16'h0000, 16'h7FFF, 1'b1, "signed");
    test_fifo_full();
    test_underrun();
    test_push_tick();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
